// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill sequencer for the two-stage icache.
//
// Accepts one S2 request at a time. A request is either a cached line fill
// (LINE_WORDS-beat INCR burst) or a single-word uncached fetch. The controller
// issues it on the AXI AR channel and collects the R beats into a line buffer.
// It then presents the line to S1 with a one-cycle rend_o pulse. busy_o stalls
// the pipeline while a request is outstanding.
//
// Optional feature macro: ICACHE_CRIT_BYPASS_EN
//   When defined, crit_valid_o/crit_word_o forward the critical word as it arrives.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_i               request valid, held by S2 until rend_o
//   req_cached_i        1 = line fill, 0 = uncached single-word read
//   req_paddr_i         physical fetch address
//   cancel_i            flush/redirect: suppress delivery of the outstanding request
//   busy_o              stall to icache
//   rend_o              one-cycle delivery pulse
//   rend_cached_o       with rend_o: 1 = install into ways, 0 = bypass
//   line_rdata_o        assembled line, word i at [32*i+31:32*i]
//   rerr_o              with rend_o: some beat of the transaction had rresp != OKAY
//   ar*_o / arready_i   AXI read address channel
//   r*_i / rready_o     AXI read data channel
//   crit_valid_o, crit_word_o   critical-word bypass (ICACHE_CRIT_BYPASS_EN only)
module icache_refill_ctrl #(
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [3:0]  AXI_ID     = 4'd0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_i,
   input  logic                       req_cached_i,
   input  logic [31:0]                req_paddr_i,
   input  logic                       cancel_i,
   output logic                       busy_o,
   output logic                       rend_o,
   output logic                       rend_cached_o,
   output logic [32*LINE_WORDS-1:0]   line_rdata_o,
   output logic                       rerr_o,
   output logic [3:0]                 arid_o,
   output logic [31:0]                araddr_o,
   output logic [7:0]                 arlen_o,
   output logic [2:0]                 arsize_o,
   output logic [1:0]                 arburst_o,
   output logic                       arvalid_o,
   input  logic                       arready_i,
   input  logic [3:0]                 rid_i,
   input  logic [31:0]                rdata_i,
   input  logic [1:0]                 rresp_i,
   input  logic                       rlast_i,
   input  logic                       rvalid_i,
`ifdef ICACHE_CRIT_BYPASS_EN
   output logic                       crit_valid_o,
   output logic [31:0]                crit_word_o,
`endif
   output logic                       rready_o
);

   localparam int unsigned OffW  = $clog2(LINE_WORDS);
   localparam int unsigned LineW = 32 * LINE_WORDS;

   typedef enum logic [1:0] {StIdle, StAr, StR, StDone} state_e;

   state_e            state_q, state_d;
   logic              cached_q, cached_d;
   logic [31:0]       paddr_q, paddr_d;
   logic [OffW-1:0]   cnt_q, cnt_d;
   logic [LineW-1:0]  line_q, line_d;
   logic              err_q, err_d;
   logic              drop_q, drop_d;
   logic [OffW-1:0]   slot;

   // Single-ID master: rid carries no information for us.
   logic unused_rid;
   assign unused_rid = ^rid_i;

   // Cached beats fill in arrival order; uncached data lands at its word offset.
   assign slot = cached_q ? cnt_q : paddr_q[OffW+1:2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cached_q <= 1'b0;
         paddr_q  <= '0;
         cnt_q    <= '0;
         line_q   <= '0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cached_q <= cached_d;
         paddr_q  <= paddr_d;
         cnt_q    <= cnt_d;
         line_q   <= line_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cached_d = cached_q;
      paddr_d  = paddr_q;
      cnt_d    = cnt_q;
      line_d   = line_q;
      err_d    = err_q;
      drop_d   = drop_q;

      case (state_q)
         StIdle: begin
            drop_d = 1'b0;
            if (req_i) begin
               paddr_d  = req_paddr_i;
               cached_d = req_cached_i;
               cnt_d    = '0;
               err_d    = 1'b0;
               // Uncached delivery carries only one word; the rest must read as zero.
               if (!req_cached_i) begin
                  line_d = '0;
               end
               state_d = StAr;
            end
         end
         StAr: begin
            if (arready_i) begin
               state_d = StR;
            end
         end
         StR: begin
            if (rvalid_i) begin
               line_d[{slot, 5'b00000} +: 32] = rdata_i;
               cnt_d = cnt_q + 1'b1;
               if (rresp_i != 2'b00) begin
                  err_d = 1'b1;
               end
               // rlast alone ends the burst, whatever the beat count.
               if (rlast_i) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // The AXI transaction still runs to completion; only delivery is dropped.
      if (cancel_i && (state_q != StIdle)) begin
         drop_d = 1'b1;
      end
   end

   assign busy_o        = (state_q != StIdle) || req_i;
   assign arvalid_o     = (state_q == StAr);
   assign rready_o      = (state_q == StR);
   assign arid_o        = AXI_ID;
   assign arsize_o      = 3'b010;
   assign arburst_o     = 2'b01;
   assign araddr_o      = cached_q ? {paddr_q[31:OffW+2], {(OffW + 2){1'b0}}} : paddr_q;
   assign arlen_o       = cached_q ? 8'(LINE_WORDS - 1) : 8'd0;
   assign rend_o        = (state_q == StDone) && !drop_q && !cancel_i;
   assign rend_cached_o = rend_o && cached_q;
   assign rerr_o        = rend_o && err_q;
   assign line_rdata_o  = line_q;

`ifdef ICACHE_CRIT_BYPASS_EN
   assign crit_valid_o = (state_q == StR) && rvalid_i && (slot == paddr_q[OffW+1:2]) &&
                         !drop_q && !cancel_i;
   assign crit_word_o  = rdata_i;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_i, req_cached_i, cancel_i;
   logic [31:0]   req_paddr_i;
   logic          busy_o, rend_o, rend_cached_o, rerr_o;
   logic [255:0]  line_rdata_o;
   logic [3:0]    arid_o;
   logic [31:0]   araddr_o;
   logic [7:0]    arlen_o;
   logic [2:0]    arsize_o;
   logic [1:0]    arburst_o;
   logic          arvalid_o, arready_i;
   logic [3:0]    rid_i;
   logic [31:0]   rdata_i;
   logic [1:0]    rresp_i;
   logic          rlast_i, rvalid_i, rready_o;
`ifdef ICACHE_CRIT_BYPASS_EN
   logic          crit_valid_o;
   logic [31:0]   crit_word_o;
`endif

   always #5 clk = ~clk;

   icache_refill_ctrl #(
      .LINE_WORDS (8),
      .AXI_ID     (4'd0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (req_i),
      .req_cached_i  (req_cached_i),
      .req_paddr_i   (req_paddr_i),
      .cancel_i      (cancel_i),
      .busy_o        (busy_o),
      .rend_o        (rend_o),
      .rend_cached_o (rend_cached_o),
      .line_rdata_o  (line_rdata_o),
      .rerr_o        (rerr_o),
      .arid_o        (arid_o),
      .araddr_o      (araddr_o),
      .arlen_o       (arlen_o),
      .arsize_o      (arsize_o),
      .arburst_o     (arburst_o),
      .arvalid_o     (arvalid_o),
      .arready_i     (arready_i),
      .rid_i         (rid_i),
      .rdata_i       (rdata_i),
      .rresp_i       (rresp_i),
      .rlast_i       (rlast_i),
      .rvalid_i      (rvalid_i),
`ifdef ICACHE_CRIT_BYPASS_EN
      .crit_valid_o  (crit_valid_o),
      .crit_word_o   (crit_word_o),
`endif
      .rready_o      (rready_o)
   );

   int            n_vec = 0;
   int            n_err = 0;
   // Reference line: what S1 should see, word by word.
   logic [31:0]   mline [8];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_line();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = mline[i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full request from S2 with a scripted AXI slave.
   // gap_mode: 0 back-to-back beats, 1 alternate rvalid 1/0, 2 random idle cycles.
   // err_beat/cancel_beat: beat index carrying SLVERR / cancel pulse (-1 for none).
   // exp_lat: expected req-to-rend cycle count, -1 to skip.
   task automatic run_txn(input bit cached, input logic [31:0] paddr, input int ar_delay,
                          input int nbeats, input int gap_mode, input int err_beat,
                          input int cancel_beat, input bit seq_data, input logic [31:0] base,
                          input int exp_lat);
      int          cyc;
      int          slot;
      bit          cancelled;
      bit          err;
      bit          gap;
      logic [31:0] d;
      logic [31:0] exp_addr;
      cancelled = 1'b0;
      err       = 1'b0;
      exp_addr  = cached ? {paddr[31:5], 5'b00000} : paddr;

      req_i = 1'b1; req_cached_i = cached; req_paddr_i = paddr;
      #1;
      chk("busy_on_req", busy_o, 1);
      if (!cached) for (int i = 0; i < 8; i++) mline[i] = 32'h0;
      tick();
      cyc = 1;

      for (int w = 0; w <= ar_delay; w++) begin
         arready_i = (w == ar_delay);
         #1;
         chk("arvalid", arvalid_o, 1);
         chk("araddr", araddr_o, exp_addr);
         chk("arlen", arlen_o, cached ? 7 : 0);
         chk("arsize", arsize_o, 2);
         chk("arburst", arburst_o, 1);
         chk("arid", arid_o, 0);
         chk("rend_in_ar", rend_o, 0);
         tick();
         cyc++;
      end
      arready_i = 1'b0;

      for (int k = 0; k < nbeats; k++) begin
         gap = ((gap_mode == 1) && (k > 0)) || ((gap_mode == 2) && ($urandom_range(0, 1) == 1));
         if (gap) begin
            rvalid_i = 1'b0;
            #1;
            chk("rready_idle", rready_o, 1);
            chk("rend_in_gap", rend_o, 0);
            tick();
            cyc++;
         end
         d        = seq_data ? base + 32'(k) : $urandom;
         rvalid_i = 1'b1;
         rdata_i  = d;
         rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
         rlast_i  = (k == nbeats - 1);
         cancel_i = (k == cancel_beat);
         if (k == cancel_beat) cancelled = 1'b1;
         slot = cached ? (k % 8) : int'(paddr[4:2]);
         #1;
         chk("rready", rready_o, 1);
         chk("rend_in_r", rend_o, 0);
`ifdef ICACHE_CRIT_BYPASS_EN
         chk("crit_valid", crit_valid_o, (slot == int'(paddr[4:2])) && !cancelled);
         if (crit_valid_o) chk("crit_word", crit_word_o, d);
`endif
         mline[slot] = d;
         if (k == err_beat) err = 1'b1;
         tick();
         cyc++;
         rvalid_i = 1'b0; rlast_i = 1'b0; cancel_i = 1'b0; rresp_i = 2'b00;
      end

      #1;
      chk("rend", rend_o, !cancelled);
      chk("rend_cached", rend_cached_o, !cancelled && cached);
      chk("rerr", rerr_o, !cancelled && err);
      chk("line", line_rdata_o, model_line());
      if (exp_lat >= 0) chk("latency", cyc, exp_lat);
      req_i = 1'b0;
      tick();
      chk("busy_after", busy_o, 0);
      chk("rend_single", rend_o, 0);
      chk("arvalid_idle", arvalid_o, 0);
   endtask

   initial begin
      bit          c;
      logic [31:0] a;
      int          nb;

      rst_n = 1'b0; req_i = 1'b0; req_cached_i = 1'b0; req_paddr_i = 32'h0; cancel_i = 1'b0;
      arready_i = 1'b0; rid_i = 4'h0; rdata_i = 32'h0; rresp_i = 2'b00; rlast_i = 1'b0;
      rvalid_i = 1'b0;
      for (int i = 0; i < 8; i++) mline[i] = 32'h0;
      repeat (3) tick();
      chk("rst_arvalid", arvalid_o, 0);
      chk("rst_rready", rready_o, 0);
      chk("rst_rend", rend_o, 0);
      chk("rst_rerr", rerr_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_line", line_rdata_o, 0);
      rst_n = 1'b1;
      tick();

      // Cached fill, zero-wait, sequential data.
      run_txn(1'b1, 32'h1FC0_0024, 0, 8, 0, -1, -1, 1'b1, 32'h100, 10);
      // Uncached single word.
      run_txn(1'b0, 32'hBFC0_0008, 0, 1, 0, -1, -1, 1'b1, 32'hDEAD_BEEF, 3);
      // Slow arready, rvalid alternating.
      run_txn(1'b1, 32'h0040_1234, 5, 8, 1, -1, -1, 1'b0, 32'h0, -1);
      // Cancel on the third beat, then a normal request.
      run_txn(1'b1, 32'h0000_2040, 0, 8, 0, -1, 2, 1'b0, 32'h0, 10);
      run_txn(1'b1, 32'h0000_3060, 0, 8, 0, -1, -1, 1'b0, 32'h0, 10);
      // SLVERR on the sixth beat.
      run_txn(1'b1, 32'h8000_0000, 0, 8, 0, 5, -1, 1'b0, 32'h0, 10);
      // Early rlast after four beats; upper words keep their previous contents.
      run_txn(1'b1, 32'h8000_0100, 0, 4, 0, -1, -1, 1'b0, 32'h0, 6);
      // Overlong burst: beats 9 and 10 wrap onto slots 0 and 1.
      run_txn(1'b1, 32'h8000_0200, 0, 10, 0, -1, -1, 1'b0, 32'h0, 12);
      // Critical word at the last slot.
      run_txn(1'b1, 32'h0000_001C, 0, 8, 0, -1, -1, 1'b1, 32'h100, 10);

      // Reset in the middle of a burst abandons it.
      req_i = 1'b1; req_cached_i = 1'b1; req_paddr_i = 32'h0000_5000;
      tick();
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
      tick();
      rvalid_i = 1'b0; req_i = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mline[i] = 32'h0;
      chk("midrst_arvalid", arvalid_o, 0);
      chk("midrst_rready", rready_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_line", line_rdata_o, 0);
      tick();

      for (int t = 0; t < 24; t++) begin
         c  = 1'($urandom_range(0, 1));
         a  = $urandom;
         nb = c ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 8) : 1;
         run_txn(c, a, $urandom_range(0, 3), nb, 2, $urandom_range(0, 15),
                 $urandom_range(0, 30) - 5, 1'b0, 32'h0, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
